// File: rtl/col_out_pkg.sv
// col_out_pkg -- shared types and sizing helpers for the column output packer.
//   pk_state_e : packer state (COLLECT gathers elements, HOLD parks a finished word)
//   lanes_f    : elements per output word
//   wpr_f      : output words per array row
//   idx_w      : index width for a counter over n items (at least 1 bit)
package col_out_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } pk_state_e;

  function automatic int lanes_f(input int out_w, input int data_w);
    return out_w / data_w;
  endfunction

  function automatic int wpr_f(input int ncols, input int lanes);
    return ncols / lanes;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/col_fifo.sv
// col_fifo -- small synchronous show-ahead FIFO, one per array column.
// Ports:
//   clk, rstn      clock, synchronous active-low reset
//   i_push, i_din  write request/data (ignored when full)
//   i_pop          read request (ignored when empty)
//   o_dout         head entry, valid whenever !o_empty
//   o_full/o_empty occupancy flags
module col_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [AW:0]       r_cnt;
  logic              w_push, w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_dout  = r_mem[r_rptr];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/col_output_packer.sv
// col_output_packer -- systolic array output stage. Skewed per-column results
// are buffered in per-column FIFOs, then drained in strict column order one
// element per cycle and packed LANES at a time into OUT_W-bit words that leave
// on a valid/ready port.
// Ports:
//   clk, rstn   clock, synchronous active-low reset
//   in_r, in_v  column data (col j at [j*DATA_W +: DATA_W]) and per-column valid
//   rread       consumer ready
//   out_r       packed word, lane k at [k*DATA_W +: DATA_W]
//   rvalid      out_r holds a word
//   overflow    sticky per-column drop flags
//   busy        data buffered anywhere in the block
//   rlast       (only with COL_OUT_ROWLAST_EN) word ends an array row
module col_output_packer
  import col_out_pkg::*;
#(
  parameter int NCOLS  = 8,
  parameter int DATA_W = 8,
  parameter int OUT_W  = 32,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NCOLS*DATA_W-1:0] in_r,
  input  logic [NCOLS-1:0]        in_v,
  input  logic                    rread,
  output logic [OUT_W-1:0]        out_r,
  output logic                    rvalid,
  output logic [NCOLS-1:0]        overflow,
  output logic                    busy
`ifdef COL_OUT_ROWLAST_EN
  ,
  output logic                    rlast
`endif
);

  localparam int LANES = lanes_f(OUT_W, DATA_W);
  localparam int WPR   = wpr_f(NCOLS, LANES);
  localparam int CW    = idx_w(NCOLS);
  localparam int LW    = idx_w(LANES);
  localparam logic [CW-1:0] LAST_COL  = CW'(NCOLS - 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  if (LANES < 1 || (OUT_W % DATA_W) != 0) begin : g_err_outw
    $error("col_output_packer: OUT_W must be a nonzero multiple of DATA_W");
  end
  if (WPR < 1 || WPR * LANES != NCOLS) begin : g_err_ncols
    $error("col_output_packer: NCOLS must be a multiple of LANES");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_err_depth
    $error("col_output_packer: DEPTH must be a power of two >= 2");
  end

  logic [NCOLS-1:0][DATA_W-1:0] w_dout;
  logic [NCOLS-1:0]             w_full, w_empty, w_pop;

  for (genvar j = 0; j < NCOLS; j++) begin : g_col
    col_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .i_push  (in_v[j]),
      .i_pop   (w_pop[j]),
      .i_din   (in_r[j*DATA_W +: DATA_W]),
      .o_dout  (w_dout[j]),
      .o_full  (w_full[j]),
      .o_empty (w_empty[j])
    );
  end

  pk_state_e        r_state;
  logic [CW-1:0]    r_col_ptr;
  logic [LW-1:0]    r_lane_cnt;
  logic [OUT_W-1:0] r_asm;

  logic             w_out_free, w_take, w_word_done;
  logic [OUT_W-1:0] w_word;

  // Output register can accept a word when empty or draining this edge.
  assign w_out_free  = !rvalid || rread;
  assign w_take      = (r_state == COLLECT) && !w_empty[r_col_ptr];
  assign w_word_done = w_take && (r_lane_cnt == LAST_LANE);

  always_comb begin
    w_pop            = '0;
    w_pop[r_col_ptr] = w_take;
    w_word           = r_asm;
    w_word[int'(r_lane_cnt)*DATA_W +: DATA_W] = w_dout[r_col_ptr];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= COLLECT;
      r_col_ptr  <= '0;
      r_lane_cnt <= '0;
      r_asm      <= '0;
      out_r      <= '0;
      rvalid     <= 1'b0;
      overflow   <= '0;
`ifdef COL_OUT_ROWLAST_EN
      rlast      <= 1'b0;
`endif
    end else begin
      // Fullness is judged before any same-cycle pop, so a pop never rescues a push.
      overflow <= overflow | (in_v & w_full);
      if (rvalid && rread) rvalid <= 1'b0;
      case (r_state)
        COLLECT: begin
          if (w_take) begin
            r_col_ptr  <= (r_col_ptr == LAST_COL) ? '0 : r_col_ptr + 1'b1;
            r_lane_cnt <= (r_lane_cnt == LAST_LANE) ? '0 : r_lane_cnt + 1'b1;
            if (!w_word_done) begin
              r_asm <= w_word;
            end else if (w_out_free) begin
              out_r  <= w_word;
              rvalid <= 1'b1;
`ifdef COL_OUT_ROWLAST_EN
              rlast  <= (r_col_ptr == LAST_COL);
`endif
            end else begin
              r_asm   <= w_word;
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (w_out_free) begin
            out_r   <= r_asm;
            rvalid  <= 1'b1;
            r_state <= COLLECT;
`ifdef COL_OUT_ROWLAST_EN
            // col_ptr already advanced past the word; wrapped to 0 means row end.
            rlast   <= (r_col_ptr == '0);
`endif
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  // Lane count is zero in HOLD, so the state term covers a parked full word.
  assign busy = !(&w_empty) || (r_lane_cnt != '0) || (r_state == HOLD) || rvalid;

endmodule

// File: tb/tb_col_output_packer.sv
module tb_col_output_packer;

  localparam int NCOLS  = 8;
  localparam int DATA_W = 8;
  localparam int OUT_W  = 32;
  localparam int DEPTH  = 4;
  localparam int LANES  = OUT_W / DATA_W;

  logic                    clk = 1'b0;
  logic                    rstn = 1'b0;
  logic [NCOLS*DATA_W-1:0] in_r = '0;
  logic [NCOLS-1:0]        in_v = '0;
  logic                    rread = 1'b0;
  logic [OUT_W-1:0]        out_r;
  logic                    rvalid;
  logic [NCOLS-1:0]        overflow;
  logic                    busy;
`ifdef COL_OUT_ROWLAST_EN
  logic                    rlast;
`endif

  always #5 clk = ~clk;

  col_output_packer #(.NCOLS(NCOLS), .DATA_W(DATA_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_r     (in_r),
    .in_v     (in_v),
    .rread    (rread),
    .out_r    (out_r),
    .rvalid   (rvalid),
    .overflow (overflow),
    .busy     (busy)
`ifdef COL_OUT_ROWLAST_EN
    ,
    .rlast    (rlast)
`endif
  );

  typedef struct {
    logic [OUT_W-1:0] w;
    logic             last;
    int               bc;
  } exp_t;

  exp_t             exp_q[$];
  int               n_vec = 0;
  int               n_err = 0;
  int               cyc = 0;
  int               xfer_q[$];
  logic [DATA_W-1:0] colq [NCOLS][$];
  int               mcol = 0;
  int               outst [NCOLS];
  logic             held = 1'b0;
  logic [OUT_W-1:0] held_w = '0;
  exp_t             mon_e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [OUT_W-1:0] w, input int bc);
    exp_t e;
    e.w    = w;
    e.bc   = bc;
    e.last = (bc + LANES == NCOLS);
    exp_q.push_back(e);
  endtask

  // Reference: each column is an ordered list of accepted elements; words are
  // formed by walking columns in row order, LANES at a time.
  task automatic model_push(input int j, input logic [DATA_W-1:0] d);
    colq[j].push_back(d);
    outst[j]++;
    while (1) begin
      bit ok;
      logic [OUT_W-1:0] w;
      ok = 1'b1;
      for (int k = 0; k < LANES; k++) if (colq[mcol+k].size() == 0) ok = 1'b0;
      if (!ok) break;
      w = '0;
      for (int k = 0; k < LANES; k++) w[k*DATA_W +: DATA_W] = colq[mcol+k].pop_front();
      push_exp(w, mcol);
      mcol = (mcol + LANES) % NCOLS;
    end
  endtask

  task automatic do_reset();
    rstn  = 1'b0;
    in_v  = '0;
    rread = 1'b0;
    tick();
    exp_q.delete();
    for (int j = 0; j < NCOLS; j++) begin
      colq[j].delete();
      outst[j] = 0;
    end
    mcol = 0;
    rstn = 1'b1;
  endtask

  task automatic drive_diag(input logic rd);
    for (int j = 0; j < NCOLS; j++) begin
      in_v = '0;
      in_v[j] = 1'b1;
      in_r = '0;
      in_r[j*DATA_W +: DATA_W] = DATA_W'(j + 1);
      rread = rd;
      tick();
    end
    in_v = '0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n;
    n = 0;
    in_v  = '0;
    rread = 1'b1;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk({nm, " drain busy"}, 64'(busy), 64'd0);
  endtask

  // Monitor: transfer happens at the next posedge when rvalid && rread now.
  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("stable rvalid", 64'(rvalid), 64'd1);
        chk("stable out_r", 64'(out_r), 64'(held_w));
      end
      if (rvalid && rread) begin
        xfer_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected word: got %0h expected none", out_r);
        end else begin
          mon_e = exp_q.pop_front();
          chk("word", 64'(out_r), 64'(mon_e.w));
`ifdef COL_OUT_ROWLAST_EN
          chk("rlast", 64'(rlast), 64'(mon_e.last));
`endif
          for (int k = 0; k < LANES; k++)
            if (outst[mon_e.bc+k] > 0) outst[mon_e.bc+k]--;
        end
      end
      held   = rvalid && !rread;
      held_w = out_r;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int need [NCOLS];
    int s, g;
    logic [DATA_W-1:0] d;

    for (int j = 0; j < NCOLS; j++) outst[j] = 0;
    do_reset();
    chk("reset out_r", 64'(out_r), 64'd0);
    chk("reset rvalid", 64'(rvalid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset overflow", 64'(overflow), 64'd0);

    // Diagonal skew, consumer always ready
    push_exp(32'h04030201, 0);
    push_exp(32'h08070605, 4);
    drive_diag(1'b1);
    wait_idle("diag", 100);
    chk("diag overflow", 64'(overflow), 64'd0);
    chk("diag leftover", 64'(exp_q.size()), 64'd0);

    // Back-pressure
    push_exp(32'h04030201, 0);
    push_exp(32'h08070605, 4);
    drive_diag(1'b0);
    repeat (10) tick();
    chk("bp rvalid", 64'(rvalid), 64'd1);
    chk("bp out_r", 64'(out_r), 64'h04030201);
    chk("bp busy", 64'(busy), 64'd1);
    wait_idle("bp", 100);
    chk("bp leftover", 64'(exp_q.size()), 64'd0);

    // Overflow on column 0: first element is popped at once, so DEPTH+2 pushes drop the last
    for (int i = 0; i < DEPTH + 2; i++) begin
      in_v = '0;
      in_v[0] = 1'b1;
      in_r = '0;
      in_r[DATA_W-1:0] = DATA_W'(i + 1);
      rread = 1'b1;
      tick();
    end
    in_v = '0;
    tick();
    chk("ovf flag", 64'(overflow), 64'h01);
    for (int r = 0; r < 5; r++) begin
      push_exp({DATA_W'(r*16+3), DATA_W'(r*16+2), DATA_W'(r*16+1), DATA_W'(r+1)}, 0);
      push_exp({DATA_W'(r*16+7), DATA_W'(r*16+6), DATA_W'(r*16+5), DATA_W'(r*16+4)}, 4);
      in_v = 8'hFE;
      for (int c = 1; c < NCOLS; c++) in_r[c*DATA_W +: DATA_W] = DATA_W'(r*16 + c);
      tick();
      in_v = '0;
      repeat (7) tick();
    end
    wait_idle("ovf", 200);
    chk("ovf sticky", 64'(overflow), 64'h01);
    chk("ovf leftover", 64'(exp_q.size()), 64'd0);

    // Reset with two lanes collected
    in_v = '1;
    for (int c = 0; c < NCOLS; c++) in_r[c*DATA_W +: DATA_W] = DATA_W'(8'hA0 + c);
    rread = 1'b1;
    tick();
    in_v = '0;
    tick();
    tick();
    do_reset();
    chk("midrst rvalid", 64'(rvalid), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst overflow", 64'(overflow), 64'd0);
    push_exp(32'h04030201, 0);
    push_exp(32'h08070605, 4);
    drive_diag(1'b1);
    wait_idle("midrst", 100);
    chk("midrst leftover", 64'(exp_q.size()), 64'd0);

    // Streaming three full rows
    xfer_q.delete();
    for (int r = 0; r < 3; r++) begin
      push_exp({DATA_W'(r*16+3), DATA_W'(r*16+2), DATA_W'(r*16+1), DATA_W'(r*16)}, 0);
      push_exp({DATA_W'(r*16+7), DATA_W'(r*16+6), DATA_W'(r*16+5), DATA_W'(r*16+4)}, 4);
      in_v = '1;
      for (int c = 0; c < NCOLS; c++) in_r[c*DATA_W +: DATA_W] = DATA_W'(r*16 + c);
      rread = 1'b1;
      tick();
    end
    wait_idle("stream", 100);
    chk("stream count", 64'(xfer_q.size()), 64'd6);
    for (int i = 1; i < xfer_q.size(); i++)
      chk("stream gap", 64'(xfer_q[i] - xfer_q[i-1]), 64'(LANES));
    chk("stream leftover", 64'(exp_q.size()), 64'd0);

    // Randomized traffic, pushes throttled so no column can overflow
    do_reset();
    for (int c = 0; c < 600; c++) begin
      in_v = '0;
      for (int j = 0; j < NCOLS; j++) begin
        if ($urandom_range(0, 99) < 50 && outst[j] < DEPTH) begin
          d = DATA_W'($urandom);
          in_v[j] = 1'b1;
          in_r[j*DATA_W +: DATA_W] = d;
          model_push(j, d);
        end
      end
      rread = ($urandom_range(0, 99) < 70);
      tick();
    end
    // Top up columns so every pending element completes a word
    s = 0;
    for (int j = 0; j < NCOLS; j++) begin
      if (j >= mcol && colq[j].size() > s) s = colq[j].size();
      if (j < mcol && colq[j].size() > 0 && colq[j].size() + 1 > s) s = colq[j].size() + 1;
    end
    for (int j = 0; j < NCOLS; j++)
      need[j] = (j >= mcol) ? s - colq[j].size() : ((s > 0) ? s - 1 - colq[j].size() : 0);
    g = 0;
    while (g < 500) begin
      bit any;
      any = 1'b0;
      in_v = '0;
      for (int j = 0; j < NCOLS; j++) begin
        if (need[j] > 0) begin
          any = 1'b1;
          if (outst[j] < DEPTH) begin
            d = DATA_W'($urandom);
            in_v[j] = 1'b1;
            in_r[j*DATA_W +: DATA_W] = d;
            model_push(j, d);
            need[j]--;
          end
        end
      end
      if (!any) break;
      rread = 1'b1;
      tick();
      g++;
    end
    wait_idle("rand", 2000);
    chk("rand overflow", 64'(overflow), 64'd0);
    chk("rand leftover", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
